// File: rtl/sram_multi_bank_rd_fetch.sv
// Read fetch controller: reads cfg_len_i words from one SRAM bank and streams them through a credit-throttled FIFO.
// Define SRAM_RD_FETCH_PERF_EN to add the credit-stall counter on stl_cnt_o.
module sram_multi_bank_rd_fetch #(
  parameter int SIZE        = 256,
  parameter int DATA_WD     = 64,
  parameter int RD_LAT      = 1,
  parameter int FIFO_DEPTH  = 4,
  parameter int NUMB_BNK    = 4,
  parameter int SIZE_WD     = $clog2(SIZE),
  parameter int NUMB_BNK_WD = (NUMB_BNK > 1) ? $clog2(NUMB_BNK) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUMB_BNK_WD-1:0] cfg_idx_bnk_i,
  input  logic [SIZE_WD-1:0]     cfg_adr_i,
  input  logic [SIZE_WD:0]       cfg_len_i,
  input  logic                   start_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [NUMB_BNK_WD-1:0] sram_idx_bnk_o,
  output logic [SIZE_WD-1:0]     sram_adr_o,
  output logic                   sram_rd_val_o,
  input  logic                   sram_rd_val_i,
  input  logic [DATA_WD-1:0]     sram_rd_dat_i,
  output logic                   out_val_o,
  input  logic                   out_rdy_i,
  output logic [DATA_WD-1:0]     out_dat_o,
  output logic                   out_lst_o,
`ifdef SRAM_RD_FETCH_PERF_EN
  output logic [15:0]            stl_cnt_o,
`endif
  output logic [1:0]             dbg_state_o
);

  // Output stream: a word transfers on any rising edge where out_val_o & out_rdy_i;
  // out_val_o never depends on out_rdy_i and out_dat_o/out_lst_o hold while stalled.

  localparam int PTR_WD = $clog2(FIFO_DEPTH);
  localparam int CNT_WD = PTR_WD + 1;
  localparam logic [CNT_WD:0]    DEPTH_C = (CNT_WD+1)'(FIFO_DEPTH);
  localparam logic [SIZE_WD-1:0] ADR_MAX = SIZE_WD'(SIZE - 1);
  localparam logic [SIZE_WD:0]   LEN_ONE = (SIZE_WD+1)'(1);

  if (FIFO_DEPTH < RD_LAT + 1) begin : g_depth_chk
    $error("FIFO_DEPTH must cover RD_LAT+1 words");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [SIZE_WD:0]       len_q, iss_rem_q, pop_cnt_q;
  logic [SIZE_WD-1:0]     adr_q;
  logic [NUMB_BNK_WD-1:0] bnk_q;
  logic                   zero_done_q;
  logic [CNT_WD-1:0]      inflight_q, fifo_cnt_q;
  logic [PTR_WD-1:0]      wr_ptr_q, rd_ptr_q;
  logic [DATA_WD-1:0]     mem_q [FIFO_DEPTH];

  logic start_acc, credit_ok, issue, push, pop;

  // Credit counts both words already in the FIFO and words still in the SRAM pipe.
  assign start_acc = (state_q == S_IDLE) && start_i;
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_cnt_q}) < DEPTH_C;
  assign issue     = (state_q == S_ISSUE) && credit_ok;
  assign push      = sram_rd_val_i && (inflight_q != '0);
  assign pop       = out_val_o && out_rdy_i;

  assign out_val_o      = (fifo_cnt_q != '0);
  assign out_dat_o      = out_val_o ? mem_q[rd_ptr_q] : '0;
  assign out_lst_o      = out_val_o && (pop_cnt_q == (len_q - LEN_ONE));
  assign busy_o         = (state_q != S_IDLE);
  assign sram_adr_o     = adr_q;
  assign sram_idx_bnk_o = bnk_q;
  assign dbg_state_o    = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    sram_rd_val_o = 1'b0;
    done_o        = zero_done_q;
    case (state_q)
      S_IDLE: begin
        if (start_acc && (cfg_len_i != '0)) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        sram_rd_val_o = credit_ok;
        if (credit_ok && (iss_rem_q == LEN_ONE)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_lst_o && pop) begin
          done_o  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q       <= '0;
      iss_rem_q   <= '0;
      pop_cnt_q   <= '0;
      adr_q       <= '0;
      bnk_q       <= '0;
      zero_done_q <= 1'b0;
      inflight_q  <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      zero_done_q <= start_acc && (cfg_len_i == '0);
      if (start_acc) begin
        len_q     <= cfg_len_i;
        iss_rem_q <= cfg_len_i;
        adr_q     <= cfg_adr_i;
        bnk_q     <= cfg_idx_bnk_i;
        pop_cnt_q <= '0;
      end else if (issue) begin
        iss_rem_q <= iss_rem_q - LEN_ONE;
        adr_q     <= (adr_q == ADR_MAX) ? '0 : adr_q + SIZE_WD'(1);
      end
      if (pop) begin
        pop_cnt_q <= pop_cnt_q + LEN_ONE;
        rd_ptr_q  <= rd_ptr_q + PTR_WD'(1);
      end
      if (push) wr_ptr_q <= wr_ptr_q + PTR_WD'(1);
      case ({issue, push})
        2'b10:   inflight_q <= inflight_q + CNT_WD'(1);
        2'b01:   inflight_q <= inflight_q - CNT_WD'(1);
        default: inflight_q <= inflight_q;
      endcase
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_WD'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_WD'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Storage needs no reset: validity is carried entirely by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sram_rd_dat_i;
  end

`ifdef SRAM_RD_FETCH_PERF_EN
  logic [15:0] stl_q;

  always_ff @(posedge clk) begin
    if (rst)                                                    stl_q <= '0;
    else if (start_acc)                                         stl_q <= '0;
    else if ((state_q == S_ISSUE) && !credit_ok && (stl_q != 16'hFFFF)) stl_q <= stl_q + 16'd1;
  end

  assign stl_cnt_o = stl_q;
`endif

endmodule

// File: tb/tb_sram_multi_bank_rd_fetch.sv
// Scoreboard bench for sram_multi_bank_rd_fetch: directed operations against an SRAM model with 1 or 2 cycle read latency.
module tb_sram_multi_bank_rd_fetch;

  localparam int SIZE       = 256;
  localparam int DATA_WD    = 64;
  localparam int FIFO_DEPTH = 4;
  localparam int NUMB_BNK   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic [1:0]         cfg_idx_bnk_i = '0;
  logic [7:0]         cfg_adr_i = '0;
  logic [8:0]         cfg_len_i = '0;
  logic               start_i = 1'b0;
  logic               busy_o, done_o;
  logic [1:0]         sram_idx_bnk_o;
  logic [7:0]         sram_adr_o;
  logic               sram_rd_val_o;
  logic               sram_rd_val_i;
  logic [63:0]        sram_rd_dat_i;
  logic               out_val_o;
  logic               out_rdy_i = 1'b0;
  logic [63:0]        out_dat_o;
  logic               out_lst_o;
  logic [1:0]         dbg_state;
`ifdef SRAM_RD_FETCH_PERF_EN
  logic [15:0]        stl_cnt_o;
`endif

  sram_multi_bank_rd_fetch #(
    .SIZE(SIZE), .DATA_WD(DATA_WD), .RD_LAT(1), .FIFO_DEPTH(FIFO_DEPTH), .NUMB_BNK(NUMB_BNK)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_idx_bnk_i(cfg_idx_bnk_i), .cfg_adr_i(cfg_adr_i), .cfg_len_i(cfg_len_i),
    .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .sram_idx_bnk_o(sram_idx_bnk_o), .sram_adr_o(sram_adr_o), .sram_rd_val_o(sram_rd_val_o),
    .sram_rd_val_i(sram_rd_val_i), .sram_rd_dat_i(sram_rd_dat_i),
    .out_val_o(out_val_o), .out_rdy_i(out_rdy_i), .out_dat_o(out_dat_o), .out_lst_o(out_lst_o),
`ifdef SRAM_RD_FETCH_PERF_EN
    .stl_cnt_o(stl_cnt_o),
`endif
    .dbg_state_o(dbg_state)
  );

  // ---------------- SRAM model (not reset, so pre-reset reads still return) ----------------
  function automatic logic [63:0] mem_word(input logic [1:0] b, input logic [7:0] a);
    return {24'hB0A000, 6'd0, b, 24'hC0D000, a};
  endfunction

  logic        lat2 = 1'b0;
  logic        p1_val = 1'b0, p2_val = 1'b0;
  logic [63:0] p1_dat = '0, p2_dat = '0;

  always @(posedge clk) begin
    p1_val <= sram_rd_val_o;
    p1_dat <= mem_word(sram_idx_bnk_o, sram_adr_o);
    p2_val <= p1_val;
    p2_dat <= p1_dat;
  end

  assign sram_rd_val_i = lat2 ? p2_val : p1_val;
  assign sram_rd_dat_i = lat2 ? p2_dat : p1_dat;

  // ---------------- scoreboard ----------------
  logic [64:0] exp_q[$];
  logic [9:0]  exp_adr_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  int op_id = 0;
  int n_iss = 0, n_out = 0, n_done = 0;
  int seen_iss_id = -1, seen_val_id = -1;
  int first_iss = 0, last_iss = 0, first_val = 0;
  logic        hold_v = 1'b0;
  logic [63:0] hold_dat = '0;

  always @(negedge clk) begin
    logic [64:0] e;
    logic [9:0]  ea;
    if (!rst) begin
      if (sram_rd_val_o) begin
        n_iss++;
        if (seen_iss_id != op_id) begin
          first_iss   = cyc;
          seen_iss_id = op_id;
        end
        last_iss = cyc;
        check_i("issue_expected", int'(exp_adr_q.size() != 0), 1);
        if (exp_adr_q.size() != 0) begin
          ea = exp_adr_q.pop_front();
          check("issue_bank_adr", 64'({sram_idx_bnk_o, sram_adr_o}), 64'(ea));
        end
      end
      if (out_val_o && (seen_val_id != op_id)) begin
        first_val   = cyc;
        seen_val_id = op_id;
      end
      if (hold_v && out_val_o) check("dat_stable", out_dat_o, hold_dat);
      hold_v   = out_val_o && !out_rdy_i;
      hold_dat = out_dat_o;
      if (out_val_o && out_rdy_i) begin
        n_out++;
        check_i("out_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("out_dat", out_dat_o, e[63:0]);
          check("out_lst", 64'(out_lst_o), 64'(e[64]));
          check("done_on_lst", 64'(done_o), 64'(e[64]));
        end
      end
      if (done_o) n_done++;
    end else begin
      hold_v = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  int b_iss = 0, b_out = 0, b_done = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mark();
    b_iss  = n_iss;
    b_out  = n_out;
    b_done = n_done;
  endtask

  // Pushes expectations, pulses start, then scrambles cfg to prove it is latched.
  task automatic run_op(input logic [1:0] b, input logic [7:0] a, input logic [8:0] len);
    logic [7:0] ad;
    ad = a;
    for (int i = 0; i < int'(len); i++) begin
      exp_adr_q.push_back({b, ad});
      exp_q.push_back({(i == int'(len) - 1), mem_word(b, ad)});
      ad = ad + 8'd1;
    end
    op_id++;
    cfg_idx_bnk_i = b;
    cfg_adr_i     = a;
    cfg_len_i     = len;
    start_i       = 1'b1;
    tick();
    start_i       = 1'b0;
    cfg_idx_bnk_i = ~b;
    cfg_adr_i     = 8'h77;
    cfg_len_i     = 9'd3;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !busy_o) break;
      tick();
    end
    check_i({name, "_complete"}, int'(exp_q.size() == 0 && !busy_o), 1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst = 1'b1;
    repeat (3) tick();
    check("reset_ctrl", 64'({busy_o, done_o, sram_rd_val_o, out_val_o, out_lst_o, dbg_state}), 64'd0);
    check("reset_addr", 64'({sram_idx_bnk_o, sram_adr_o}), 64'd0);
    check("reset_dat", out_dat_o, 64'd0);
    rst = 1'b0;
    repeat (2) tick();

    // T1: len 8 from address 0 on bank 1, one-cycle SRAM
    lat2 = 1'b0; out_rdy_i = 1'b1;
    mark();
    run_op(2'd1, 8'd0, 9'd8);
    check_i("t1_busy", int'(busy_o), 1);
    wait_idle("t1", 60);
    check_i("t1_issues", n_iss - b_iss, 8);
    check_i("t1_words", n_out - b_out, 8);
    check_i("t1_dones", n_done - b_done, 1);
    check_i("t1_b2b_issue", last_iss - first_iss, 7);
    check_i("t1_latency", first_val - first_iss, 2);
    check("t1_bank_held", 64'(sram_idx_bnk_o), 64'd1);

    // T2: address wrap from SIZE-2
    mark();
    run_op(2'd2, 8'(SIZE - 2), 9'd6);
    wait_idle("t2", 60);
    check_i("t2_words", n_out - b_out, 6);
    check_i("t2_dones", n_done - b_done, 1);

    // T3: two-cycle SRAM, consumer stalled 20 cycles
    lat2 = 1'b1; out_rdy_i = 1'b0;
    mark();
    run_op(2'd3, 8'h20, 9'd16);
    repeat (20) tick();
    check_i("t3_stall_issues", n_iss - b_iss, FIFO_DEPTH);
    check_i("t3_stall_words", n_out - b_out, 0);
    check_i("t3_stall_val", int'(out_val_o), 1);
    out_rdy_i = 1'b1;
    wait_idle("t3", 120);
    check_i("t3_words", n_out - b_out, 16);
    check_i("t3_dones", n_done - b_done, 1);
    check_i("t3_latency", first_val - first_iss, 3);
`ifdef SRAM_RD_FETCH_PERF_EN
    check_i("t3_stl_cnt", int'(stl_cnt_o), (last_iss - first_iss + 1) - 16);
`endif

    // T4: zero length
    lat2 = 1'b0;
    mark();
    run_op(2'd1, 8'h55, 9'd0);
    check_i("t4_done_pulse", int'(done_o), 1);
    tick();
    check_i("t4_done_drop", int'(done_o), 0);
    repeat (3) tick();
    check_i("t4_no_issue", n_iss - b_iss, 0);
    check_i("t4_no_val", int'(seen_val_id == op_id), 0);
    check_i("t4_dones", n_done - b_done, 1);

    // T5: second start with different cfg while busy is ignored
    mark();
    run_op(2'd2, 8'd10, 9'd5);
    tick();
    cfg_idx_bnk_i = 2'd3; cfg_adr_i = 8'd100; cfg_len_i = 9'd3; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    wait_idle("t5", 60);
    check_i("t5_issues", n_iss - b_iss, 5);
    check_i("t5_words", n_out - b_out, 5);
    check_i("t5_dones", n_done - b_done, 1);
    check("t5_bank_held", 64'(sram_idx_bnk_o), 64'd2);

    // T6: reset with two reads inflight, then a clean restart
    lat2 = 1'b1;
    mark();
    run_op(2'd2, 8'h40, 9'd8);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("t6_rst_ctrl", 64'({busy_o, done_o, sram_rd_val_o, out_val_o, out_lst_o, dbg_state}), 64'd0);
    check("t6_rst_addr", 64'({sram_idx_bnk_o, sram_adr_o}), 64'd0);
    check("t6_rst_dat", out_dat_o, 64'd0);
    rst = 1'b0;
    exp_q.delete();
    exp_adr_q.delete();
    op_id++;
    mark();
    repeat (6) tick();
    check_i("t6_stray_words", n_out - b_out, 0);
    check_i("t6_stray_val", int'(seen_val_id == op_id), 0);
    check_i("t6_no_issue", n_iss - b_iss, 0);
    mark();
    run_op(2'd1, 8'hF0, 9'd4);
    wait_idle("t6", 60);
    check_i("t6_words", n_out - b_out, 4);
    check_i("t6_dones", n_done - b_done, 1);

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
